pipeline_hazard_controller: RTL and testbench
=============================================

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have parameter HALT_OPCODE, default 4'hF, opcode (ifid_inst[15:12]) that halts the pipeline.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 1, range 1-7, number of cycles IF/ID is flushed per taken branch/jump.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ifid_inst  input  16  instruction in IF/ID; op1 = [11:8], op2 = [7:4].
REQ-006 SHALL have port idex_mem_read  input  1  instruction in ID/EX is a load.
REQ-007 SHALL have port idex_rd  input  4  destination register of ID/EX instruction.
REQ-008 SHALL have port branch_taken  input  1  branch or jump resolved taken this cycle.
REQ-009 SHALL have port dmem_busy  input  1  data memory not ready; whole pipeline must freeze.
REQ-010 SHALL have port pc_write  output  1  PC load enable.
REQ-011 SHALL have port ifid_write  output  1  IF/ID write enable (IFIDWrite).
REQ-012 SHALL have port ifid_flush  output  1  IF/ID clear (flush).
REQ-013 SHALL have port haz_mux_con  output  1  next-address mux select: 1 = add 0 (hold), 0 = add 2.
REQ-014 SHALL have port idex_bubble  output  1  force control bits of ID/EX to zero.
REQ-015 SHALL have port pipe_freeze  output  1  hold ID/EX, EX/MEM, MEM/WB.
REQ-016 SHALL have port halted  output  1  pipeline halted.
REQ-017 SHALL have ports stall_count, flush_count  output  16 each  performance counters.

Function
REQ-018 SHALL implement states RUN, FLUSH, MEMWAIT, HALT in a registered state variable; outputs are functions of state and current inputs.
REQ-019 SHALL define load_use = idex_mem_read AND (idex_rd == ifid_inst[11:8] OR idex_rd == ifid_inst[7:4]); all 16 registers compared, no R0 exception.
REQ-020 SHALL, in RUN, apply priority dmem_busy > branch_taken > load_use > halt opcode > normal.
REQ-021 SHALL, in RUN with no event: pc_write=1, ifid_write=1, haz_mux_con=0, all others 0.
REQ-022 SHALL, on dmem_busy (any state except HALT): pc_write=0, ifid_write=0, haz_mux_con=1, pipe_freeze=1, ifid_flush=0, idex_bubble=0; state MEMWAIT next cycle; MEMWAIT holds while dmem_busy=1 and returns to RUN the cycle after dmem_busy=0.
REQ-023 SHALL, on branch_taken in RUN: pc_write=1, ifid_write=1, ifid_flush=1 same cycle; if FLUSH_CYCLES>1, enter FLUSH with a 3-bit down-counter loaded FLUSH_CYCLES-1, ifid_flush=1 each FLUSH cycle, return to RUN when counter reaches 0; flush_count increments once per event.
REQ-024 SHALL, on load_use in RUN: pc_write=0, ifid_write=0, haz_mux_con=1, idex_bubble=1 for exactly that cycle; state stays RUN (bubble clears hazard next cycle).
REQ-025 SHALL, on ifid_inst[15:12]==HALT_OPCODE in RUN with no higher event: enter HALT next cycle; in HALT pc_write=0, ifid_write=0, haz_mux_con=1, idex_bubble=1, halted=1; only reset exits HALT; dmem_busy ignored in HALT.
REQ-026 SHALL ignore branch_taken and load_use while in MEMWAIT or while dmem_busy=1 (re-evaluated after unfreeze, since pipeline contents are held).
REQ-027 SHALL, in FLUSH, give dmem_busy priority: counter and flush pause, pipe_freeze=1, resume FLUSH after unfreeze with counter unchanged.
REQ-028 SHALL increment stall_count every cycle where pc_write=0 due to load_use or dmem_busy (not HALT), saturating at 16'hFFFF.
REQ-029 SHALL saturate flush_count at 16'hFFFF; neither counter wraps.

Reset
REQ-030 SHALL, when reset=1 at a rising edge, set state=RUN, flush counter=0, stall_count=0, flush_count=0, from any state including mid-FLUSH, MEMWAIT or HALT.
REQ-031 SHALL drive, during reset cycles, pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, haz_mux_con=0, pipe_freeze=0, halted=0.

Verification
REQ-032 SHALL verify load-use: idex_mem_read=1, idex_rd=4'h3, ifid_inst=16'h1340 -> one cycle pc_write=0, ifid_write=0, haz_mux_con=1, idex_bubble=1, stall_count=1.
REQ-033 SHALL verify branch with FLUSH_CYCLES=2: branch_taken pulse 1 cycle -> ifid_flush=1 for 2 consecutive cycles, flush_count=1, state RUN after.
REQ-034 SHALL verify freeze priority: dmem_busy=1 for 3 cycles with branch_taken=1 and load_use true -> pipe_freeze=1, ifid_flush=0, idex_bubble=0 for 3 cycles, stall_count=3.
REQ-035 SHALL verify halt: ifid_inst=16'hF000 -> halted=1 from next cycle, persists 10 cycles with dmem_busy toggling; reset -> halted=0, state RUN.
REQ-036 SHALL verify saturation: force 65537 stall cycles -> stall_count=16'hFFFF, no wrap.
REQ-037 SHALL verify reset during FLUSH (FLUSH_CYCLES=4, reset at second flush cycle) -> next cycle RUN, ifid_flush=0, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, taken-branch flushes,
// data-memory freezes and halt, plus saturating stall/flush performance counters.
module pipeline_hazard_controller #(
    parameter logic [3:0]  HALT_OPCODE  = 4'hF,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ifid_inst,
    input  logic        idex_mem_read,
    input  logic [3:0]  idex_rd,
    input  logic        branch_taken,
    input  logic        dmem_busy,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic        haz_mux_con,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic        halted,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {RUN, FLUSH, MEMWAIT, HALT} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       load_use;
    logic       halt_op;
    logic       stall_evt;
    logic       flush_evt;
    logic       unused_imm;

    assign load_use   = idex_mem_read && ((idex_rd == ifid_inst[11:8]) || (idex_rd == ifid_inst[7:4]));
    assign halt_op    = (ifid_inst[15:12] == HALT_OPCODE);
    assign unused_imm = ^ifid_inst[3:0];

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no path infers a latch.
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        haz_mux_con = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;
        stall_evt   = 1'b0;
        flush_evt   = 1'b0;

        if (reset) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state == HALT) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            haz_mux_con = 1'b1;
            idex_bubble = 1'b1;
            halted      = 1'b1;
        end else if (dmem_busy) begin
            // A freeze inside FLUSH parks the flush sequence in place with its counter intact.
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            haz_mux_con = 1'b1;
            pipe_freeze = 1'b1;
            stall_evt   = 1'b1;
            if (state != FLUSH) state_nxt = MEMWAIT;
        end else if (state == FLUSH) begin
            ifid_flush = 1'b1;
            fcnt_nxt   = fcnt - 3'd1;
            if (fcnt == 3'd1) state_nxt = RUN;
        end else if (state == MEMWAIT) begin
            state_nxt = RUN;
        end else if (branch_taken) begin
            ifid_flush = 1'b1;
            flush_evt  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                fcnt_nxt  = FLUSH_LOAD;
            end
        end else if (load_use) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            haz_mux_con = 1'b1;
            idex_bubble = 1'b1;
            stall_evt   = 1'b1;
        end else if (halt_op) begin
            state_nxt = HALT;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            fcnt        <= 3'd0;
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (stall_evt && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
            if (flush_evt && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized and directed bench for pipeline_hazard_controller; two instances
// (FLUSH_CYCLES 2 and 4) are compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

    logic        clk = 1'b0;
    logic        reset, idex_mem_read, branch_taken, dmem_busy;
    logic [15:0] ifid_inst;
    logic [3:0]  idex_rd;
    logic [6:0]  outs    [2];
    logic [15:0] stall_c [2];
    logic [15:0] flush_c [2];
    int          total = 0;
    int          bad   = 0;
    int          fc    [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic pw, iw, fl, hz, bb, fz, ht;
        pipeline_hazard_controller #(.HALT_OPCODE(4'hF), .FLUSH_CYCLES(g == 0 ? 2 : 4)) dut (
            .clk(clk), .reset(reset), .ifid_inst(ifid_inst), .idex_mem_read(idex_mem_read),
            .idex_rd(idex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
            .pc_write(pw), .ifid_write(iw), .ifid_flush(fl), .haz_mux_con(hz),
            .idex_bubble(bb), .pipe_freeze(fz), .halted(ht),
            .stall_count(stall_c[g]), .flush_count(flush_c[g])
        );
        assign outs[g] = {pw, iw, fl, hz, bb, fz, ht};
    end

    // Output vectors: {pc_write, ifid_write, ifid_flush, haz_mux_con, idex_bubble, pipe_freeze, halted}
    localparam logic [6:0] O_NRM = 7'b1100000;
    localparam logic [6:0] O_FLS = 7'b1110000;
    localparam logic [6:0] O_FRZ = 7'b0001010;
    localparam logic [6:0] O_STL = 7'b0001100;
    localparam logic [6:0] O_HLT = 7'b0001101;
    localparam logic [6:0] O_RST = 7'b1110100;

    // Abstract pipeline condition: halted flag, remaining extra flush cycles, waiting-on-memory flag.
    typedef struct {
        bit h;
        bit w;
        int left;
        int stall;
        int flush;
    } mdl_t;

    mdl_t m [2];

    function automatic int sat(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    function automatic void model(input int f, input mdl_t s, output logic [6:0] o, output mdl_t n);
        bit lu;
        lu = idex_mem_read && (idex_rd == ifid_inst[11:8] || idex_rd == ifid_inst[7:4]);
        n = s;
        if (reset) begin
            o = O_RST;
            n = '{h: 1'b0, w: 1'b0, left: 0, stall: 0, flush: 0};
        end else if (s.h) begin
            o = O_HLT;
        end else if (dmem_busy) begin
            o = O_FRZ;
            n.stall = sat(s.stall + 1);
            if (s.left == 0) n.w = 1'b1;
        end else if (s.left > 0) begin
            o = O_FLS;
            n.left = s.left - 1;
        end else if (s.w) begin
            o = O_NRM;
            n.w = 1'b0;
        end else if (branch_taken) begin
            o = O_FLS;
            n.flush = sat(s.flush + 1);
            n.left = f - 1;
        end else if (lu) begin
            o = O_STL;
            n.stall = sat(s.stall + 1);
        end else begin
            o = O_NRM;
            if (ifid_inst[15:12] == 4'hF) n.h = 1'b1;
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        logic [6:0] o [2];
        mdl_t       n [2];
        for (int i = 0; i < 2; i++) model(fc[i], m[i], o[i], n[i]);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("outs%0d", i), 32'(outs[i]), 32'(o[i]));
            check($sformatf("stall%0d", i), 32'(stall_c[i]), 32'(m[i].stall));
            check($sformatf("flush%0d", i), 32'(flush_c[i]), 32'(m[i].flush));
        end
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic drive(input bit r, input bit busy, input bit br, input bit mr,
                         input logic [3:0] rd, input logic [15:0] inst);
        reset = r; dmem_busy = busy; branch_taken = br;
        idex_mem_read = mr; idex_rd = rd; ifid_inst = inst;
        tick();
    endtask

    initial begin
        logic [15:0] inst;
        logic [3:0]  rd;
        fc[0] = 2;
        fc[1] = 4;
        m[0] = '{h: 1'b0, w: 1'b0, left: 0, stall: 0, flush: 0};
        m[1] = m[0];
        reset = 1'b1; dmem_busy = 1'b0; branch_taken = 1'b0;
        idex_mem_read = 1'b0; idex_rd = 4'h0; ifid_inst = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;

        // reset cycles
        repeat (2) drive(1, 0, 0, 0, 4'h0, 16'h0000);

        // load-use: one stall cycle
        drive(0, 0, 0, 1, 4'h3, 16'h1340);
        check("lu_stall_cnt", 32'(stall_c[0]), 32'd1);
        drive(0, 0, 0, 0, 4'h0, 16'h0000);

        // branch pulse: two flush cycles on FLUSH_CYCLES=2
        drive(0, 0, 1, 0, 4'h0, 16'h0000);
        repeat (4) drive(0, 0, 0, 0, 4'h0, 16'h0000);
        check("br_flush_cnt", 32'(flush_c[0]), 32'd1);

        // freeze dominates branch and load-use
        drive(1, 0, 0, 0, 4'h0, 16'h0000);
        repeat (3) drive(0, 1, 1, 1, 4'h3, 16'h1340);
        check("frz_stall_cnt", 32'(stall_c[0]), 32'd3);
        check("frz_flush_cnt", 32'(flush_c[0]), 32'd0);
        repeat (2) drive(0, 0, 0, 0, 4'h0, 16'h0000);

        // halt persists through dmem_busy toggling until reset
        drive(0, 0, 0, 0, 4'h0, 16'hF000);
        for (int i = 0; i < 10; i++) drive(0, i[0], 0, 0, 4'h0, 16'h0000);
        check("halt_hold", 32'(outs[0][0]), 32'd1);
        drive(1, 0, 0, 0, 4'h0, 16'h0000);
        drive(0, 0, 0, 0, 4'h0, 16'h0000);
        check("halt_cleared", 32'(outs[0][0]), 32'd0);

        // reset in the second flush cycle of the FLUSH_CYCLES=4 instance
        drive(0, 0, 1, 0, 4'h0, 16'h0000);
        drive(1, 0, 0, 0, 4'h0, 16'h0000);
        drive(0, 0, 0, 0, 4'h0, 16'h0000);
        reset = 1'b0;
        #1;
        check("rst_flush_out", 32'(outs[1][4]), 32'd0);
        check("rst_flush_cnt", 32'(flush_c[1]), 32'd0);
        check("rst_stall_cnt", 32'(stall_c[1]), 32'd0);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            inst = 16'($urandom);
            inst[15:12] = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
            rd = ($urandom_range(0, 2) == 0) ? inst[11:8] : 4'($urandom);
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 1) == 1, rd, inst);
        end

        // stall counter saturation
        drive(1, 0, 0, 0, 4'h0, 16'h0000);
        for (int i = 0; i < 65537; i++) drive(0, 1, $urandom_range(0, 1) == 1, 0, 4'h0, 16'h0000);
        check("sat_stall0", 32'(stall_c[0]), 32'h0000FFFF);
        check("sat_stall1", 32'(stall_c[1]), 32'h0000FFFF);
        drive(0, 1, 0, 0, 4'h0, 16'h0000);
        check("sat_nowrap", 32'(stall_c[0]), 32'h0000FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
